// File: rtl/drone_pwm_pkg.sv
// Shared constants and FSM encoding for the RC/ESC pulse writer and reader.
package drone_pwm_pkg;

  localparam int TICKS_PER_MS    = 256;
  localparam int PWM_VALUE_WIDTH = 8;

  // Default frame timing; the reader derives its decode limits from these.
  localparam int DEF_TICK_DIV       = 208;
  localparam int DEF_BASE_TICKS     = TICKS_PER_MS;
  localparam int DEF_FRAME_TICKS    = 20 * TICKS_PER_MS;
  localparam int DEF_TIMEOUT_FRAMES = 10;

  localparam logic [1:0] PWM_ST_IDLE = 2'd0;
  localparam logic [1:0] PWM_ST_HIGH = 2'd1;
  localparam logic [1:0] PWM_ST_LOW  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = PWM_ST_IDLE,
    HIGH = PWM_ST_HIGH,
    LOW  = PWM_ST_LOW
  } pwm_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides sys_clk into a one-cycle tick enable every TICK_DIV cycles.
module tick_prescaler
  import drone_pwm_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick_en
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Enable lands on the TICK_DIV-th cycle after reset release.
  assign tick_en = (r_cnt == LAST);

endmodule

// File: rtl/esc_pwm_writer.sv
// Servo/ESC pulse generator: (BASE_TICKS + value) tick pulse every FRAME_TICKS, with arm and failsafe.
module esc_pwm_writer
  import drone_pwm_pkg::*;
#(
  parameter int VALUE_WIDTH    = PWM_VALUE_WIDTH,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int BASE_TICKS     = DEF_BASE_TICKS,
  parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   cmd_valid,
  input  logic [VALUE_WIDTH-1:0] cmd_data,
  output logic                   cmd_ready,
  input  logic                   arm,
  output logic                   pwm_out,
  output logic                   frame_strobe,
  output logic                   timeout
);

  localparam int TW = $clog2(FRAME_TICKS + 1);
  localparam int FW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TW-1:0] BASE_T  = TW'(BASE_TICKS);
  localparam logic [TW-1:0] FRAME_T = TW'(FRAME_TICKS);
  localparam logic [FW-1:0] TO_LIM  = FW'(TIMEOUT_FRAMES);

  function automatic logic [TW-1:0] pulse_end(input logic [VALUE_WIDTH-1:0] v);
    return BASE_T + TW'(v);
  endfunction

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] c);
    return (c >= TO_LIM) ? c : c + FW'(1);
  endfunction

  pwm_state_e             r_state;
  pwm_state_e             w_state_nxt;
  logic [TW-1:0]          r_tick_cnt;
  logic [TW-1:0]          w_cnt_inc;
  logic [VALUE_WIDTH-1:0] r_pend;
  logic [VALUE_WIDTH-1:0] r_act;
  logic [VALUE_WIDTH-1:0] w_pend_src;
  logic [FW-1:0]          r_frames;
  logic [FW-1:0]          w_frames_inc;
  logic                   r_timeout;
  logic                   w_timeout_fs;
  logic                   r_pwm;
  logic                   r_strobe;
  logic                   w_tick_en;
  logic                   w_accept;
  logic                   w_frame_start;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tick_en (w_tick_en)
  );

  assign cmd_ready = ~sys_rst;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_cnt_inc = r_tick_cnt + TW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    if (w_tick_en) begin
      case (r_state)
        IDLE: begin
          w_state_nxt   = HIGH;
          w_frame_start = 1'b1;
        end
        HIGH: begin
          if (w_cnt_inc == pulse_end(r_act)) w_state_nxt = LOW;
        end
        LOW: begin
          if (w_cnt_inc == FRAME_T) begin
            w_state_nxt   = HIGH;
            w_frame_start = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A write landing on the frame-start cycle is bypassed and counts as fresh.
  assign w_pend_src   = w_accept ? cmd_data : r_pend;
  assign w_frames_inc = sat_inc(r_frames);
  assign w_timeout_fs = ~w_accept & (r_timeout | (w_frames_inc == TO_LIM));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_pend     <= '0;
      r_act      <= '0;
      r_frames   <= '0;
      r_timeout  <= 1'b1;
      r_pwm      <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pwm    <= (w_state_nxt == HIGH);
      r_strobe <= w_frame_start;
      if (w_tick_en) r_tick_cnt <= w_frame_start ? '0 : w_cnt_inc;
      if (w_accept) r_pend <= cmd_data;
      if (w_frame_start) begin
        r_act     <= (arm & ~w_timeout_fs) ? w_pend_src : '0;
        r_frames  <= w_accept ? '0 : w_frames_inc;
        r_timeout <= w_timeout_fs;
      end else if (w_accept) begin
        r_frames  <= '0;
        r_timeout <= 1'b0;
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign frame_strobe = r_strobe;
  assign timeout      = r_timeout;

endmodule
